// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler
// Shares one UART transmitter between two requesters (0: ALU result path,
// 1: register-file read path). Arbitrates round-robin, captures a one- or
// two-byte word and feeds it to the transmitter low byte first, one frame per
// byte, with a programmable inter-frame gap and a watchdog for a transmitter
// that never raises BUSY.

module uart_tx_scheduler #(
    parameter int DATA_WIDTH   = 8,
    parameter int IFG_CYCLES   = 1,
    parameter int BUSY_TIMEOUT = 16
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    REQ0,
    input  logic [2*DATA_WIDTH-1:0] DATA0,
    input  logic                    LEN0,
    input  logic                    REQ1,
    input  logic [2*DATA_WIDTH-1:0] DATA1,
    input  logic                    LEN1,
    output logic                    GNT0,
    output logic                    GNT1,
    output logic [DATA_WIDTH-1:0]   TX_P_DATA,
    output logic                    TX_DATA_VALID,
    input  logic                    TX_BUSY,
    output logic                    SCHED_BUSY,
    output logic                    CUR_SRC,
    output logic                    ERR
);

    // One counter serves both the busy watchdog and the gap timer, so it is
    // sized for the larger of the two limits.
    localparam int CNT_MAX = (BUSY_TIMEOUT > IFG_CYCLES) ? BUSY_TIMEOUT : IFG_CYCLES;
    localparam int CW      = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);

    // Terminal counts: the event fires on the edge where the count would
    // reach the limit, so compare against limit-1 before incrementing.
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(BUSY_TIMEOUT - 1);
    localparam logic [CW-1:0] GAP_LAST     = CW'(IFG_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WAIT_BUSY,
        WAIT_DONE,
        GAP
    } state_t;

    state_t                  state;
    logic [CW-1:0]           cnt;
    logic                    rr_ptr;
    logic [2*DATA_WIDTH-1:0] word_q;
    logic                    len_q;
    logic                    high_phase;
    logic                    winner;
    logic                    high_pending;

    // The high byte is still owed when the word is two bytes long and the
    // byte just finished was the low one.
    assign high_pending = len_q && !high_phase;

    // Pick the requester to grant: a lone requester wins, a tie goes to the
    // one that was not served last.
    always_comb begin
        winner = 1'b0;
        if (REQ0 && REQ1) begin
            winner = ~rr_ptr;
        end else if (REQ1) begin
            winner = 1'b1;
        end
    end

    // Main sequencer: grant, strobe each byte, wait out the frame and the gap.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state         <= IDLE;
            cnt           <= '0;
            rr_ptr        <= 1'b1;
            word_q        <= '0;
            len_q         <= 1'b0;
            high_phase    <= 1'b0;
            GNT0          <= 1'b0;
            GNT1          <= 1'b0;
            TX_P_DATA     <= '0;
            TX_DATA_VALID <= 1'b0;
            SCHED_BUSY    <= 1'b0;
            CUR_SRC       <= 1'b0;
            ERR           <= 1'b0;
        end else begin
            GNT0          <= 1'b0;
            GNT1          <= 1'b0;
            TX_DATA_VALID <= 1'b0;
            ERR           <= 1'b0;
            case (state)
                IDLE: begin
                    if ((REQ0 || REQ1) && !TX_BUSY) begin
                        word_q        <= winner ? DATA1 : DATA0;
                        len_q         <= winner ? LEN1 : LEN0;
                        high_phase    <= 1'b0;
                        GNT0          <= ~winner;
                        GNT1          <= winner;
                        CUR_SRC       <= winner;
                        rr_ptr        <= winner;
                        SCHED_BUSY    <= 1'b1;
                        TX_P_DATA     <= winner ? DATA1[DATA_WIDTH-1:0] : DATA0[DATA_WIDTH-1:0];
                        TX_DATA_VALID <= 1'b1;
                        state         <= LOAD;
                    end
                end
                LOAD: begin
                    cnt   <= '0;
                    state <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (TX_BUSY) begin
                        state <= WAIT_DONE;
                    end else if (cnt == TIMEOUT_LAST) begin
                        ERR        <= 1'b1;
                        SCHED_BUSY <= 1'b0;
                        state      <= IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                WAIT_DONE: begin
                    if (!TX_BUSY) begin
                        if (IFG_CYCLES != 0) begin
                            cnt   <= '0;
                            state <= GAP;
                        end else if (high_pending) begin
                            high_phase    <= 1'b1;
                            TX_P_DATA     <= word_q[2*DATA_WIDTH-1:DATA_WIDTH];
                            TX_DATA_VALID <= 1'b1;
                            state         <= LOAD;
                        end else begin
                            SCHED_BUSY <= 1'b0;
                            state      <= IDLE;
                        end
                    end
                end
                GAP: begin
                    if (cnt == GAP_LAST) begin
                        if (high_pending) begin
                            high_phase    <= 1'b1;
                            TX_P_DATA     <= word_q[2*DATA_WIDTH-1:DATA_WIDTH];
                            TX_DATA_VALID <= 1'b1;
                            state         <= LOAD;
                        end else begin
                            SCHED_BUSY <= 1'b0;
                            state      <= IDLE;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Testbench for uart_tx_scheduler: a behavioural transmitter model answers
// each DATA_VALID strobe, a monitor logs strobes/grants/errors with cycle
// stamps, and each scenario task checks the log against expectations built
// from the word, its length and the round-robin rule.

module tb_uart_tx_scheduler;

    localparam int DW  = 8;
    localparam int IFG = 1;
    localparam int TMO = 16;

    logic          CLK   = 1'b0;
    logic          RST   = 1'b1;
    logic          REQ0  = 1'b0;
    logic          LEN0  = 1'b0;
    logic          REQ1  = 1'b0;
    logic          LEN1  = 1'b0;
    logic [2*DW-1:0] DATA0 = '0;
    logic [2*DW-1:0] DATA1 = '0;
    logic          GNT0;
    logic          GNT1;
    logic [DW-1:0] TX_P_DATA;
    logic          TX_DATA_VALID;
    logic          TX_BUSY;
    logic          SCHED_BUSY;
    logic          CUR_SRC;
    logic          ERR;

    logic tx_auto    = 1'b1;
    logic tx_force   = 1'b0;
    logic model_busy = 1'b0;
    int   tx_delay   = 1;
    int   tx_hold    = 10;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic prev_busy  = 1'b0;
    logic prev_sched = 1'b0;
    logic prev_dv    = 1'b0;

    logic [DW-1:0] dv_bytes[$];
    int            dv_cyc[$];
    logic          gnt_src[$];
    int            err_cyc[$];
    int            bfall_cyc[$];
    int            sfall_cyc[$];

    // Source served most recently according to the round-robin rule (1 after reset).
    logic model_last = 1'b1;

    assign TX_BUSY = tx_auto ? model_busy : tx_force;

    uart_tx_scheduler #(
        .DATA_WIDTH  (DW),
        .IFG_CYCLES  (IFG),
        .BUSY_TIMEOUT(TMO)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .REQ0         (REQ0),
        .DATA0        (DATA0),
        .LEN0         (LEN0),
        .REQ1         (REQ1),
        .DATA1        (DATA1),
        .LEN1         (LEN1),
        .GNT0         (GNT0),
        .GNT1         (GNT1),
        .TX_P_DATA    (TX_P_DATA),
        .TX_DATA_VALID(TX_DATA_VALID),
        .TX_BUSY      (TX_BUSY),
        .SCHED_BUSY   (SCHED_BUSY),
        .CUR_SRC      (CUR_SRC),
        .ERR          (ERR)
    );

    // 100 MHz clock.
    always #5 CLK = ~CLK;

    // Transmitter model: BUSY rises tx_delay cycles after a strobe and stays up tx_hold cycles.
    initial begin
        forever begin
            @(posedge CLK);
            #1;
            if (tx_auto && TX_DATA_VALID) begin
                repeat (tx_delay) @(posedge CLK);
                #1;
                model_busy = 1'b1;
                repeat (tx_hold) @(posedge CLK);
                #1;
                model_busy = 1'b0;
            end
        end
    end

    // Monitor: log strobes, grants, errors and falling edges with cycle stamps.
    initial begin
        forever begin
            @(posedge CLK);
            #2;
            cyc++;
            if (TX_DATA_VALID) begin
                dv_bytes.push_back(TX_P_DATA);
                dv_cyc.push_back(cyc);
                checks++;
                if (prev_dv) begin
                    errors++;
                    $display("[TB] FAIL dv_width: strobe high %0d cycles, expected 1", 2);
                end
            end
            if (GNT0 || GNT1) begin
                checks++;
                if (GNT0 && GNT1) begin
                    errors++;
                    $display("[TB] FAIL gnt_exclusive: GNT0=%0b GNT1=%0b, expected one-hot", GNT0, GNT1);
                end
                gnt_src.push_back(GNT1);
            end
            if (ERR) err_cyc.push_back(cyc);
            if (prev_busy && !TX_BUSY) bfall_cyc.push_back(cyc);
            if (prev_sched && !SCHED_BUSY) sfall_cyc.push_back(cyc);
            prev_busy  = TX_BUSY;
            prev_sched = SCHED_BUSY;
            prev_dv    = TX_DATA_VALID;
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog");
    end

    task automatic clear_logs();
        dv_bytes.delete();
        dv_cyc.delete();
        gnt_src.delete();
        err_cyc.delete();
        bfall_cyc.delete();
        sfall_cyc.delete();
    endtask

    task automatic wait_grant(input string name, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge CLK);
            if (GNT0 || GNT1) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("[TB] FAIL %s_grant: no grant within 60 cycles, expected one", name);
        end
    endtask

    task automatic wait_idle(input string name);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge CLK);
            if (!SCHED_BUSY && !TX_BUSY) begin
                done = 1'b1;
                break;
            end
        end
        checks++;
        if (!done) begin
            errors++;
            $display("[TB] FAIL %s_idle: SCHED_BUSY=%0b after 200 cycles, expected 0", name, SCHED_BUSY);
        end
        repeat (2) @(negedge CLK);
    endtask

    task automatic test_reset();
        RST = 1'b1;
        repeat (3) @(negedge CLK);
        checks++;
        if ({GNT0, GNT1, TX_P_DATA, TX_DATA_VALID, SCHED_BUSY, CUR_SRC, ERR} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got %0h, expected 0",
                     {GNT0, GNT1, TX_P_DATA, TX_DATA_VALID, SCHED_BUSY, CUR_SRC, ERR});
        end
        RST = 1'b0;
        model_last = 1'b1;
        repeat (2) @(negedge CLK);
        checks++;
        if ({GNT0, GNT1, TX_DATA_VALID, SCHED_BUSY, ERR} !== 5'b0) begin
            errors++;
            $display("[TB] FAIL idle_outputs: got %0b, expected 0", {GNT0, GNT1, TX_DATA_VALID, SCHED_BUSY, ERR});
        end
    endtask

    task automatic test_single_byte();
        bit ok;
        clear_logs();
        tx_auto = 1'b1; tx_delay = 1; tx_hold = 10;
        DATA0 = {8'($urandom), 8'hA5};
        LEN0  = 1'b0;
        REQ0  = 1'b1;
        wait_grant("single", ok);
        REQ0 = 1'b0;
        model_last = 1'b0;
        checks++;
        if ({GNT0, GNT1, CUR_SRC, SCHED_BUSY, TX_DATA_VALID, TX_P_DATA} !== {5'b10011, 8'hA5}) begin
            errors++;
            $display("[TB] FAIL single_grant_state: got %0h, expected %0h",
                     {GNT0, GNT1, CUR_SRC, SCHED_BUSY, TX_DATA_VALID, TX_P_DATA}, {5'b10011, 8'hA5});
        end
        wait_idle("single");
        checks++;
        if (dv_bytes.size() != 1 || dv_bytes[0] !== 8'hA5) begin
            errors++;
            $display("[TB] FAIL single_bytes: got %0d strobes, expected 1 strobe of a5", dv_bytes.size());
        end
        checks++;
        if (gnt_src.size() != 1 || err_cyc.size() != 0) begin
            errors++;
            $display("[TB] FAIL single_events: got %0d grants %0d errs, expected 1 and 0", gnt_src.size(), err_cyc.size());
        end
        checks++;
        if (sfall_cyc.size() != 1 || bfall_cyc.size() != 1) begin
            errors++;
            $display("[TB] FAIL single_falls: got %0d/%0d falls, expected 1/1", sfall_cyc.size(), bfall_cyc.size());
        end else if (sfall_cyc[0] - bfall_cyc[0] != IFG + 1) begin
            errors++;
            $display("[TB] FAIL single_gap: got %0d cycles, expected %0d", sfall_cyc[0] - bfall_cyc[0], IFG + 1);
        end
    endtask

    task automatic test_two_bytes();
        bit ok;
        clear_logs();
        tx_auto = 1'b1; tx_delay = $urandom_range(1, 3); tx_hold = $urandom_range(2, 10);
        DATA1 = 16'h3C5A;
        LEN1  = 1'b1;
        REQ1  = 1'b1;
        wait_grant("two", ok);
        REQ1 = 1'b0;
        model_last = 1'b1;
        checks++;
        if ({GNT1, CUR_SRC, TX_P_DATA} !== {2'b11, 8'h5A}) begin
            errors++;
            $display("[TB] FAIL two_grant_state: got %0h, expected %0h", {GNT1, CUR_SRC, TX_P_DATA}, {2'b11, 8'h5A});
        end
        wait_idle("two");
        checks++;
        if (dv_bytes.size() != 2) begin
            errors++;
            $display("[TB] FAIL two_count: got %0d strobes, expected 2", dv_bytes.size());
        end else begin
            checks++;
            if (dv_bytes[0] !== 8'h5A || dv_bytes[1] !== 8'h3C) begin
                errors++;
                $display("[TB] FAIL two_order: got %0h %0h, expected 5a 3c", dv_bytes[0], dv_bytes[1]);
            end
            checks++;
            if (bfall_cyc.size() < 1 || dv_cyc[1] - bfall_cyc[0] != IFG + 1) begin
                errors++;
                $display("[TB] FAIL two_gap: got %0d fall records, expected second strobe %0d cycles after first fall",
                         bfall_cyc.size(), IFG + 1);
            end
        end
        checks++;
        if (gnt_src.size() != 1 || err_cyc.size() != 0) begin
            errors++;
            $display("[TB] FAIL two_events: got %0d grants %0d errs, expected 1 and 0", gnt_src.size(), err_cyc.size());
        end
    endtask

    task automatic test_arbitration();
        bit ok;
        logic exp_w;
        logic [DW-1:0] exp_b;
        clear_logs();
        tx_auto = 1'b1; tx_delay = 1; tx_hold = 3;
        DATA0 = {8'($urandom), 8'h11}; LEN0 = 1'b0;
        DATA1 = {8'($urandom), 8'h22}; LEN1 = 1'b0;
        REQ0 = 1'b1; REQ1 = 1'b1;
        for (int g = 0; g < 4; g++) begin
            exp_w = ~model_last;
            exp_b = exp_w ? 8'h22 : 8'h11;
            wait_grant("arb", ok);
            if (g == 3) begin
                REQ0 = 1'b0; REQ1 = 1'b0;
            end
            checks++;
            if ({GNT1, GNT0, TX_P_DATA} !== {exp_w, ~exp_w, exp_b}) begin
                errors++;
                $display("[TB] FAIL arb_grant[%0d]: got GNT1=%0b GNT0=%0b byte %0h, expected src %0d byte %0h",
                         g, GNT1, GNT0, TX_P_DATA, exp_w, exp_b);
            end
            model_last = exp_w;
        end
        wait_idle("arb");
        checks++;
        if (dv_bytes.size() != 4 || gnt_src.size() != 4) begin
            errors++;
            $display("[TB] FAIL arb_count: got %0d strobes %0d grants, expected 4 and 4", dv_bytes.size(), gnt_src.size());
        end
    endtask

    task automatic test_random();
        bit ok;
        int sel;
        logic r0, r1, exp_w, exp_len;
        logic [2*DW-1:0] exp_word;
        logic [DW-1:0] exp_q[$];
        for (int t = 0; t < 10; t++) begin
            clear_logs();
            exp_q.delete();
            tx_auto = 1'b1; tx_delay = $urandom_range(1, TMO); tx_hold = $urandom_range(1, 8);
            sel = $urandom_range(1, 3);
            r0 = sel[0]; r1 = sel[1];
            DATA0 = 16'($urandom); LEN0 = 1'($urandom);
            DATA1 = 16'($urandom); LEN1 = 1'($urandom);
            exp_w    = (r0 && r1) ? ~model_last : r1;
            exp_word = exp_w ? DATA1 : DATA0;
            exp_len  = exp_w ? LEN1 : LEN0;
            exp_q.push_back(exp_word[DW-1:0]);
            if (exp_len) exp_q.push_back(exp_word[2*DW-1:DW]);
            REQ0 = r0; REQ1 = r1;
            wait_grant("rand", ok);
            REQ0 = 1'b0; REQ1 = 1'b0;
            model_last = exp_w;
            checks++;
            if ({GNT1, GNT0, CUR_SRC} !== {exp_w, ~exp_w, exp_w}) begin
                errors++;
                $display("[TB] FAIL rand_src[%0d]: got GNT1=%0b GNT0=%0b CUR_SRC=%0b, expected src %0d",
                         t, GNT1, GNT0, CUR_SRC, exp_w);
            end
            wait_idle("rand");
            checks++;
            if (dv_bytes.size() != exp_q.size()) begin
                errors++;
                $display("[TB] FAIL rand_count[%0d]: got %0d strobes, expected %0d", t, dv_bytes.size(), exp_q.size());
            end else begin
                foreach (exp_q[i]) begin
                    checks++;
                    if (dv_bytes[i] !== exp_q[i]) begin
                        errors++;
                        $display("[TB] FAIL rand_byte[%0d.%0d]: got %0h, expected %0h", t, i, dv_bytes[i], exp_q[i]);
                    end
                end
            end
            checks++;
            if (err_cyc.size() != 0 || sfall_cyc.size() != 1 || bfall_cyc.size() == 0) begin
                errors++;
                $display("[TB] FAIL rand_events[%0d]: got %0d errs %0d sched falls, expected 0 and 1",
                         t, err_cyc.size(), sfall_cyc.size());
            end else if (sfall_cyc[0] - bfall_cyc[bfall_cyc.size()-1] != IFG + 1) begin
                errors++;
                $display("[TB] FAIL rand_gap[%0d]: got %0d cycles, expected %0d",
                         t, sfall_cyc[0] - bfall_cyc[bfall_cyc.size()-1], IFG + 1);
            end
        end
    endtask

    task automatic test_timeout();
        bit ok;
        bit seen;
        logic [DW-1:0] b1;
        clear_logs();
        tx_auto = 1'b0; tx_force = 1'b0;
        DATA0 = 16'($urandom); LEN0 = 1'b1;
        REQ0 = 1'b1;
        wait_grant("tmo", ok);
        REQ0 = 1'b0;
        model_last = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            if (ERR) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen || SCHED_BUSY !== 1'b0) begin
            errors++;
            $display("[TB] FAIL tmo_err: got ERR seen=%0b SCHED_BUSY=%0b, expected 1 and 0", seen, SCHED_BUSY);
        end
        repeat (6) @(negedge CLK);
        checks++;
        if (err_cyc.size() != 1 || dv_cyc.size() != 1) begin
            errors++;
            $display("[TB] FAIL tmo_events: got %0d errs %0d strobes, expected 1 and 1", err_cyc.size(), dv_cyc.size());
        end else if (err_cyc[0] - dv_cyc[0] != TMO + 1) begin
            errors++;
            $display("[TB] FAIL tmo_latency: got %0d cycles, expected %0d", err_cyc[0] - dv_cyc[0], TMO + 1);
        end
        clear_logs();
        tx_auto = 1'b1; tx_delay = 2; tx_hold = 4;
        b1 = 8'($urandom);
        DATA1 = {8'($urandom), b1}; LEN1 = 1'b0;
        REQ1 = 1'b1;
        wait_grant("tmo_next", ok);
        REQ1 = 1'b0;
        model_last = 1'b1;
        wait_idle("tmo_next");
        checks++;
        if (gnt_src.size() != 1 || gnt_src[0] !== 1'b1 || dv_bytes.size() != 1 || dv_bytes[0] !== b1 || err_cyc.size() != 0) begin
            errors++;
            $display("[TB] FAIL tmo_next: got %0d grants %0d strobes %0d errs, expected src 1 one byte %0h no err",
                     gnt_src.size(), dv_bytes.size(), err_cyc.size(), b1);
        end
    endtask

    task automatic test_timeout_boundary();
        bit ok;
        for (int d = TMO; d <= TMO + 1; d++) begin
            clear_logs();
            tx_auto = 1'b1; tx_delay = d; tx_hold = 3;
            DATA0 = 16'($urandom); LEN0 = 1'b0;
            REQ0 = 1'b1;
            wait_grant("bound", ok);
            REQ0 = 1'b0;
            model_last = 1'b0;
            wait_idle("bound");
            checks++;
            if (err_cyc.size() != ((d > TMO) ? 1 : 0)) begin
                errors++;
                $display("[TB] FAIL bound_err[delay %0d]: got %0d errs, expected %0d", d, err_cyc.size(), (d > TMO) ? 1 : 0);
            end
            checks++;
            if (dv_bytes.size() != 1) begin
                errors++;
                $display("[TB] FAIL bound_strobes[delay %0d]: got %0d, expected 1", d, dv_bytes.size());
            end
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        bit busy_seen;
        logic [2*DW-1:0] w;
        clear_logs();
        tx_auto = 1'b1; tx_delay = 1; tx_hold = 8;
        w = 16'($urandom);
        DATA0 = w; LEN0 = 1'b1;
        REQ0 = 1'b1;
        wait_grant("rst", ok);
        busy_seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            if (TX_BUSY) begin
                busy_seen = 1'b1;
                break;
            end
        end
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        checks++;
        if (!busy_seen || {GNT0, GNT1, TX_P_DATA, TX_DATA_VALID, SCHED_BUSY, CUR_SRC, ERR} !== '0) begin
            errors++;
            $display("[TB] FAIL rst_mid_outputs: got %0h busy_seen=%0b, expected 0 and 1",
                     {GNT0, GNT1, TX_P_DATA, TX_DATA_VALID, SCHED_BUSY, CUR_SRC, ERR}, busy_seen);
        end
        RST = 1'b0;
        model_last = 1'b1;
        wait_grant("rst_regrant", ok);
        REQ0 = 1'b0;
        model_last = 1'b0;
        checks++;
        if (GNT0 !== 1'b1 || TX_P_DATA !== w[DW-1:0] || dv_bytes.size() != 2) begin
            errors++;
            $display("[TB] FAIL rst_regrant: got GNT0=%0b byte %0h after %0d strobes, expected 1 byte %0h after 2",
                     GNT0, TX_P_DATA, dv_bytes.size(), w[DW-1:0]);
        end
        wait_idle("rst");
        checks++;
        if (dv_bytes.size() != 3 || err_cyc.size() != 0 || gnt_src.size() != 2) begin
            errors++;
            $display("[TB] FAIL rst_events: got %0d strobes %0d errs %0d grants, expected 3 0 2",
                     dv_bytes.size(), err_cyc.size(), gnt_src.size());
        end else begin
            checks++;
            if (dv_bytes[1] !== w[DW-1:0] || dv_bytes[2] !== w[2*DW-1:DW]) begin
                errors++;
                $display("[TB] FAIL rst_bytes: got %0h %0h, expected %0h %0h", dv_bytes[1], dv_bytes[2], w[DW-1:0], w[2*DW-1:DW]);
            end
        end
    endtask

    task automatic test_busy_idle();
        logic [DW-1:0] b0;
        clear_logs();
        tx_auto = 1'b0; tx_force = 1'b1;
        b0 = 8'($urandom);
        DATA0 = {8'($urandom), b0}; LEN0 = 1'b0;
        REQ0 = 1'b1;
        repeat (6) @(negedge CLK);
        checks++;
        if (gnt_src.size() != 0 || SCHED_BUSY !== 1'b0) begin
            errors++;
            $display("[TB] FAIL busy_hold: got %0d grants SCHED_BUSY=%0b, expected 0 and 0", gnt_src.size(), SCHED_BUSY);
        end
        tx_force = 1'b0;
        @(negedge CLK);
        checks++;
        if (GNT0 !== 1'b1 || TX_P_DATA !== b0) begin
            errors++;
            $display("[TB] FAIL busy_release: got GNT0=%0b byte %0h, expected 1 byte %0h", GNT0, TX_P_DATA, b0);
        end
        REQ0 = 1'b0;
        model_last = 1'b0;
        @(negedge CLK);
        tx_force = 1'b1;
        repeat (3) @(negedge CLK);
        tx_force = 1'b0;
        wait_idle("busy");
        checks++;
        if (dv_bytes.size() != 1 || err_cyc.size() != 0 || gnt_src.size() != 1) begin
            errors++;
            $display("[TB] FAIL busy_events: got %0d strobes %0d errs %0d grants, expected 1 0 1",
                     dv_bytes.size(), err_cyc.size(), gnt_src.size());
        end
        tx_auto = 1'b1;
    endtask

    // Scenario sequence.
    initial begin
        test_reset();
        test_single_byte();
        test_two_bytes();
        test_arbitration();
        test_random();
        test_timeout();
        test_timeout_boundary();
        test_reset_mid();
        test_busy_idle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
- Shares the UART transmitter (serializer/parity/FSM datapath, handshake DATA_VALID/P_DATA/BUSY) between two requesters: requester 0 (ALU result path) and requester 1 (register-file read path).
- Arbitrates round-robin, captures a 1- or 2-byte word, and sequences it into the transmitter LSB-first, one frame per byte.
- Enforces a programmable inter-frame gap and recovers from a transmitter that never starts a frame.
- Sits in the UART clock domain between the system controller's response path and the TX block.

Parameters:
- DATA_WIDTH, 8, width of one transmitted byte; request words are 2*DATA_WIDTH.
- IFG_CYCLES, 1, idle cycles between BUSY falling and the next DATA_VALID (0 allowed).
- BUSY_TIMEOUT, 16, cycles allowed from a DATA_VALID pulse until BUSY must rise.

Ports:
- CLK  in  1  clock; all logic on rising edge.
- RST  in  1  synchronous reset, active-high.
- REQ0  in  1  requester 0 request (level).
- DATA0  in  2*DATA_WIDTH  requester 0 word.
- LEN0  in  1  0 = send DATA0[7:0] only, 1 = send low byte then high byte.
- REQ1, DATA1, LEN1  in  1 / 2*DATA_WIDTH / 1  same for requester 1.
- GNT0  out  1  one-cycle pulse: requester 0 word captured.
- GNT1  out  1  one-cycle pulse: requester 1 word captured.
- TX_P_DATA  out  DATA_WIDTH  byte to transmitter.
- TX_DATA_VALID  out  1  one-cycle load strobe to transmitter.
- TX_BUSY  in  1  transmitter busy.
- SCHED_BUSY  out  1  high from grant until the transaction is finished.
- CUR_SRC  out  1  source of the transaction in progress (hold value in IDLE).
- ERR  out  1  one-cycle pulse on BUSY timeout.

Behaviour:
- All outputs are registered. On RST=1 at a clock edge, every output goes to 0, the FSM goes to IDLE, counters clear and the RR pointer becomes 1, so requester 0 wins first. Applies mid-transaction: the remaining byte is dropped, no GNT and no ERR are issued.
- States: IDLE, LOAD, WAIT_BUSY, WAIT_DONE, GAP.
- IDLE:
  - If any REQ=1 and TX_BUSY=0, pick the winner. If only one requests, it wins. If both request, the winner is the one not equal to the RR pointer.
  - Next edge: capture DATA/LEN, GNTn=1, CUR_SRC=n, SCHED_BUSY=1, pointer=n, go to LOAD.
  - If TX_BUSY=1 in IDLE, no grant.
- LOAD: TX_DATA_VALID=1 for exactly this cycle. TX_P_DATA = current byte: low byte first, high byte second. TX_P_DATA stays stable until the byte leaves WAIT_DONE. Next state is WAIT_BUSY with the timeout counter cleared.
- Latency: REQ sampled high at edge k gives GNT and state LOAD at edge k+1, and TX_DATA_VALID high during cycle k+1..k+2.
- WAIT_BUSY:
  - On TX_BUSY=1, go to WAIT_DONE.
  - Otherwise increment the counter. When it reaches BUSY_TIMEOUT: ERR=1 for one cycle, abandon any remaining byte, SCHED_BUSY=0, go to IDLE.
- WAIT_DONE: on TX_BUSY=0, go to GAP, or skip GAP if IFG_CYCLES=0.
- GAP:
  - Count IFG_CYCLES.
  - Then, if a second byte is pending (LEN=1 and the low byte is done), go to LOAD with the high byte.
  - Else SCHED_BUSY=0 and go to IDLE.
- Requests are level-sensitive:
  - A requester must deassert REQ in the cycle after GNT unless it intends a new transaction.
  - A REQ still high in IDLE is treated as a new request.
  - REQ changes during a transaction are ignored. DATA/LEN are sampled only at the grant edge.
- GNT0 and GNT1 are never high together. TX_DATA_VALID is never high outside LOAD.
- Upper DATA bits are ignored when LEN=0.

Test Plan:
- Single byte: REQ0=1, DATA0=16'h00A5, LEN0=0; model TX raising BUSY 1 cycle after DATA_VALID and holding it 10 cycles -> GNT0 one pulse, one DATA_VALID with TX_P_DATA=8'hA5, SCHED_BUSY drops IFG_CYCLES+1 cycles after BUSY falls.
- Two bytes: REQ1=1, DATA1=16'h3C5A, LEN1=1 -> GNT1 once, CUR_SRC=1, DATA_VALID with 8'h5A, then after BUSY fall + 1 gap cycle DATA_VALID with 8'h3C; exactly 2 strobes.
- Arbitration: REQ0 and REQ1 high continuously, single-byte words 8'h11/8'h22 -> grant order 0,1,0,1; TX bytes alternate 11,22,11,22.
- Timeout: REQ0 single byte, TX_BUSY held 0 -> ERR pulses once 16 cycles after the DATA_VALID cycle, SCHED_BUSY=0, no second strobe; the next REQ1 is served normally.
- Reset mid-op: LEN0=1, assert RST during the first byte's WAIT_DONE -> next edge all outputs 0, no high-byte strobe after release; REQ0 still high then regrants requester 0.
- Busy at idle: TX_BUSY=1 while REQ0=1 -> no GNT until TX_BUSY=0, then GNT0 next edge.
